// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its predictor.
// Optional feature macro used by this slice: FETCH_STATIC_PRED_EN.
package fetch_pc_gen_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One FIFO entry, MSB to LSB: instruction, its PC, prediction, predicted target
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pred_taken;
    logic [ADDR_WIDTH-1:0]  target_pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    MISS    = 2'd1,
    BLOCKED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_static_predictor.sv
// Static branch predictor: JAL always taken, conditional branches taken when
// backward (sign bit of the offset set), everything else falls through.
// Only built when FETCH_STATIC_PRED_EN is defined; otherwise the file is empty.
`ifdef FETCH_STATIC_PRED_EN
module fetch_pc_gen_static_predictor
  import fetch_pc_gen_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   pred_taken_c,
  output logic [ADDR_WIDTH-1:0]  target_pc_c
);

  logic signed [20:0]    j_off;
  logic signed [12:0]    b_off;
  logic [ADDR_WIDTH-1:0] j_imm;
  logic [ADDR_WIDTH-1:0] b_imm;
  logic                  is_jal;
  logic                  is_branch;

  // Reassemble the scrambled J/B immediates and sign-extend to address width
  assign j_off     = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_off     = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm     = ADDR_WIDTH'(j_off);
  assign b_imm     = ADDR_WIDTH'(b_off);
  assign is_jal    = (instr[6:0] == OPC_JAL);
  assign is_branch = (instr[6:0] == OPC_BRANCH);

  // Select prediction and target; sums wrap at address width
  always_comb begin
    pred_taken_c = 1'b0;
    target_pc_c  = pc + ADDR_WIDTH'(4);
    if (is_jal) begin
      pred_taken_c = 1'b1;
      target_pc_c  = pc + j_imm;
    end else if (is_branch && instr[31]) begin
      pred_taken_c = 1'b1;
      target_pc_c  = pc + b_imm;
    end
  end

endmodule
`endif

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, looks up the icache, optionally
// predicts branches, and offers one registered entry per hit to the fetch FIFO.
// Optional static prediction is enabled with the macro FETCH_STATIC_PRED_EN.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  output logic                   icache_req_valid,
  output logic [ADDR_WIDTH-1:0]  icache_req_addr,
  input  logic                   icache_hit,
  input  logic [INSTR_WIDTH-1:0] icache_instr,
  input  logic                   fifo_ready_enq,
  output logic                   fifo_valid_enq,
  output logic [ENTRY_WIDTH-1:0] fifo_data_enq,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   fetch_stall
);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  out_valid_q;
  fetch_entry_t          out_data_q;

  logic                  can_adv;
  logic                  capture;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  fetch_entry_t          packet;
  logic [1:0]            unused_redirect_bits;

  // Output register is free, or is being drained this cycle
  assign can_adv          = !out_valid_q || fifo_ready_enq;
  assign capture          = icache_hit && icache_req_valid;
  assign pc_plus4         = pc_q + ADDR_WIDTH'(4);
  assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_bits = redirect_pc[1:0];

`ifdef FETCH_STATIC_PRED_EN
  fetch_pc_gen_static_predictor u_static_predictor (
    .instr        (icache_instr),
    .pc           (pc_q),
    .pred_taken_c (pred_taken),
    .target_pc_c  (target_pc)
  );
`else
  assign pred_taken = 1'b0;
  assign target_pc  = pc_plus4;
`endif

  assign next_pc = target_pc;

  assign packet = '{
    instr:      icache_instr,
    pc:         pc_q,
    pred_taken: pred_taken,
    target_pc:  target_pc
  };

  // State register
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect wins, otherwise track miss / back-pressure
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH, MISS: begin
          if (!can_adv) begin
            state_d = BLOCKED;
          end else if (icache_hit) begin
            state_d = FETCH;
          end else begin
            state_d = MISS;
          end
        end
        BLOCKED: begin
          if (fifo_ready_enq) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Handshake and status outputs
  always_comb begin
    icache_req_valid = 1'b0;
    fifo_valid_enq   = 1'b0;
    fetch_stall      = 1'b0;
    icache_req_valid = can_adv && !redirect_valid;
    fifo_valid_enq   = out_valid_q && !redirect_valid;
    fetch_stall      = (state_q == MISS) || (state_q == BLOCKED);
  end

  assign icache_req_addr = pc_q;
  assign fifo_data_enq   = out_data_q;

  // PC and output entry register: redirect reloads PC and squashes the entry
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_aligned;
      out_valid_q <= 1'b0;
    end else if (capture) begin
      pc_q        <= next_pc;
      out_valid_q <= 1'b1;
      out_data_q  <= packet;
    end else if (fifo_ready_enq) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: driver predicts entries into a queue,
// a negedge monitor checks handshake outputs and pops entries on acceptance.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] ADDI   = 32'h0010_8093;  // addi x1,x1,1
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;  // beq x0,x0,-8

  logic                   clk = 1'b0;
  logic                   rst_aL = 1'b0;
  logic                   icache_req_valid;
  logic [ADDR_WIDTH-1:0]  icache_req_addr;
  logic                   icache_hit = 1'b0;
  logic [INSTR_WIDTH-1:0] icache_instr = '0;
  logic                   fifo_ready_enq = 1'b0;
  logic                   fifo_valid_enq;
  logic [ENTRY_WIDTH-1:0] fifo_data_enq;
  logic                   redirect_valid = 1'b0;
  logic [ADDR_WIDTH-1:0]  redirect_pc = '0;
  logic                   fetch_stall;

  always #5 clk = ~clk;

  fetch_pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_aL           (rst_aL),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_hit       (icache_hit),
    .icache_instr     (icache_instr),
    .fifo_ready_enq   (fifo_ready_enq),
    .fifo_valid_enq   (fifo_valid_enq),
    .fifo_data_enq    (fifo_data_enq),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_stall      (fetch_stall)
  );

  // Reference model state: entries awaiting acceptance, fetch PC, stall reason
  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  int           m_mode;   // 0 running, 1 waiting on a miss, 2 held by the FIFO
  bit           in_reset = 1'b1;
  bit           done = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural prediction rules from instruction fields, plain integer math
  function automatic void predict(input logic [31:0] pc, input logic [31:0] ins,
                                  output bit taken, output logic [31:0] tgt);
    int off;
    off   = 4;
    taken = 1'b0;
`ifdef FETCH_STATIC_PRED_EN
    if (ins[6:0] == 7'h6F) begin
      off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
            - (ins[31] ? 1048576 : 0);
      taken = 1'b1;
    end else if (ins[6:0] == 7'h63 && ins[31]) begin
      off = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - 4096;
      taken = 1'b1;
    end
`endif
    tgt = pc + 32'(off);
  endfunction

  // Advance the model across one clock edge given the inputs of that cycle
  function automatic void model_update(bit hit, logic [31:0] ins, bit ready, bit redir,
                                       logic [31:0] rpc);
    bit           can_adv;
    bit           taken;
    logic [31:0]  tgt;
    fetch_entry_t e;
    can_adv = (exp_q.size() == 0) || ready;
    if (redir) begin
      exp_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_mode = 0;
      return;
    end
    if (m_mode == 2)   m_mode = ready ? 0 : 2;
    else if (!can_adv) m_mode = 2;
    else if (hit)      m_mode = 0;
    else               m_mode = 1;
    if (can_adv && hit) begin
      predict(m_pc, ins, taken, tgt);
      e.instr      = ins;
      e.pc         = m_pc;
      e.pred_taken = taken;
      e.target_pc  = tgt;
      exp_q.push_back(e);
      m_pc = tgt;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_pc   = RST_PC;
    m_mode = 0;
  endfunction

  // Called at posedge+1: apply inputs for one cycle, then step the model
  task automatic drive(bit hit, logic [31:0] ins, bit ready, bit redir, logic [31:0] rpc);
    icache_hit     = hit;
    icache_instr   = ins;
    fifo_ready_enq = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clk);
    model_update(hit, ins, ready, redir, rpc);
    #1;
  endtask

  task automatic mid_reset();
    icache_hit = 1'b0; fifo_ready_enq = 1'b0; redirect_valid = 1'b0;
    rst_aL   = 1'b0;
    in_reset = 1'b1;
    #2;
    check("async_rst_valid", 128'(fifo_valid_enq), 128'(0));
    check("async_rst_addr", 128'(icache_req_addr), 128'(RST_PC));
    check("async_rst_stall", 128'(fetch_stall), 128'(0));
    @(posedge clk);
    #1;
    model_reset();
    rst_aL   = 1'b1;
    in_reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return ADDI;
      1: return {1'b1, r[30:7], 7'h63};
      2: return {1'b0, r[30:7], 7'h63};
      3: return {r[31:7], 7'h6F};
      default: return r;
    endcase
  endfunction

  // Monitor: compare handshake outputs and the offered entry every cycle
  initial begin : monitor
    bit exp_valid;
    bit exp_req;
    forever begin
      @(negedge clk);
      if (!in_reset && !done) begin
        exp_valid = (exp_q.size() != 0) && !redirect_valid;
        exp_req   = ((exp_q.size() == 0) || fifo_ready_enq) && !redirect_valid;
        check("req_addr", 128'(icache_req_addr), 128'(m_pc));
        check("req_valid", 128'(icache_req_valid), 128'(exp_req));
        check("fifo_valid", 128'(fifo_valid_enq), 128'(exp_valid));
        check("fetch_stall", 128'(fetch_stall), 128'(m_mode != 0));
        if (exp_valid) begin
          check("entry", 128'(fifo_data_enq), 128'(exp_q[0]));
          if (fifo_ready_enq) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] exp_addr;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_aL   = 1'b1;
    in_reset = 1'b0;

    // Straight-line hits, then a backward branch at 0x1008
    drive(1, ADDI, 1, 0, 0);
    drive(1, ADDI, 1, 0, 0);
    drive(1, BEQ_M8, 1, 0, 0);
`ifdef FETCH_STATIC_PRED_EN
    exp_addr = 32'h0000_1000;
`else
    exp_addr = 32'h0000_100C;
`endif
    check("beq_next_addr", 128'(icache_req_addr), 128'(exp_addr));
    drive(0, 0, 1, 0, 0);

    // Three misses at 0x1004, then the hit
    drive(0, 0, 1, 1, 32'h0000_1004);
    repeat (3) drive(0, 0, 1, 0, 0);
    check("miss_hold_addr", 128'(icache_req_addr), 128'(32'h0000_1004));
    drive(1, ADDI, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Back-pressure: entry held for four cycles, then accepted with a new request
    drive(0, 0, 1, 1, 32'h0000_3000);
    drive(1, ADDI, 0, 0, 0);
    repeat (4) drive(1, ADDI, 0, 0, 0);
    drive(1, ADDI, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Redirect in the same cycle as a hit with a pending entry
    drive(1, ADDI, 1, 0, 0);
    drive(1, ADDI, 1, 1, 32'h0000_2002);
    check("redirect_addr", 128'(icache_req_addr), 128'(32'h0000_2000));
    drive(0, 0, 1, 0, 0);

    // Redirect held several cycles, then wrap of the PC sum
    repeat (3) drive(1, ADDI, 1, 1, 32'hFFFF_FFFC);
    drive(1, ADDI, 1, 0, 0);
    check("wrap_addr", 128'(icache_req_addr), 128'(0));
    drive(1, ADDI, 0, 0, 0);

    // Reset with an entry pending
    mid_reset();
    drive(1, ADDI, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom);
    end
    drive(0, 0, 1, 0, 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
